drc_lookup: RTL and testbench
=============================

// Module: drc_lookup
// PURPOSE
//  Lookup/update controller on the DRC side of SRAM_IF (drc_rd + drc_wr modports), direct client of the tag/data SRAM.
//  Accepts 24-bit address requests, reads the indexed set, compares tags across all ways, returns hit/miss plus line.
//  On hit, writes back the hit line with its 15-bit use count incremented (saturating). Keeps hit/miss statistics.
// PARAMETERS
//  N_ENTRY    64  total SRAM lines; IDX_SIZE=$clog2(N_ENTRY/N_WAY) (=4)
//  N_WAY      4   associativity; WAY_WIDTH=$clog2(N_WAY) (=2); TAG_SIZE=24-IDX_SIZE (=20)
// PORTS
//  clk          in   1              clock, all state on rising edge
//  rst_n        in   1              asynchronous active-low reset
//  req_valid    in   1              lookup request valid
//  req_ready    out  1              request accepted when valid&ready
//  req_addr     in   24             lookup address: idx=[IDX_SIZE-1:0], tag=[23:IDX_SIZE]
//  rsp_valid    out  1              response valid, held until rsp_ready
//  rsp_ready    in   1              response consumed when valid&ready
//  rsp_hit      out  1              1=hit, 0=miss
//  rsp_way      out  WAY_WIDTH      hit way (0 on miss)
//  rsp_type     out  2              line type (0 on miss)
//  rsp_syn      out  32             line syndrome (0 on miss)
//  rsp_cnt      out  15             post-increment count (0 on miss)
//  rsp_data     out  272            line data (0 on miss)
//  raddr/rden   out  IDX_SIZE/1     SRAM read port; rdata_* valid cycle after rden
//  rdata_valid/type/syn/tag/cnt/data  in  N_WAY x {1,2,32,TAG_SIZE,15,272}  per-way read data
//  waddr/wren/wdata_line  out  IDX_SIZE/1/WAY_WIDTH  SRAM write port
//  wdata_type/syn/tag/cnt/data  out  2/32/TAG_SIZE/15/272  write data
//  stat_clr     in   1              synchronous clear of statistics
//  hit_count    out  16             hits, saturates at 16'hFFFF
//  miss_count   out  16             misses, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: state=IDLE; req_ready=1 (IDLE decode); rsp_*, rden, wren, raddr, waddr, wdata_*, counters all 0.
//  FSM IDLE->RD->CMP->{UPD->RESP | RESP}->IDLE; req_ready=1 only in IDLE.
//  IDLE: on req_valid, register idx_q/tag_q, go RD. Otherwise stay.
//  RD: rden=1, raddr=idx_q for exactly one cycle; go CMP.
//  CMP: rdata_* valid. hit[w]=rdata_valid[w] & (rdata_tag[w]==tag_q). Multiple hits -> lowest w wins.
//   Hit: register way/type/syn/data, cnt_q = (rdata_cnt==15'h7FFF) ? 15'h7FFF : rdata_cnt+1; go UPD.
//   Miss: rsp fields zeroed, rsp_hit=0; go RESP.
//  UPD: wren=1 one cycle: waddr=idx_q, wdata_line=way, tag=tag_q, type/syn/data unchanged, cnt=cnt_q; go RESP.
//  RESP: rsp_valid=1, fields stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE, rsp_valid drops next cycle.
//  Latency from acceptance (cycle 0): rden cycle 1; wren cycle 3 (hit); rsp_valid cycle 4 hit / cycle 3 miss.
//  Throughput: one lookup in flight; next req accepted the cycle after the response handshake.
//  Hazard: UPD write lands before next RD (>=2 cycles later), so back-to-back hits on same line see updated count.
//  rden/wren never asserted together; both 0 outside RD/UPD. raddr/waddr hold last value when idle.
//  Counters: +1 (saturating) in the CMP cycle on hit/miss; stat_clr zeroes both and wins over same-cycle increment.
//  Async reset mid-op: abort to IDLE, outputs to reset values; a write already in UPD may or may not land.
// TESTING
//  Empty SRAM (all rdata_valid=0), req 24'h123455 -> rden at cyc1 raddr=5, rsp at cyc3 hit=0, all fields 0, wren never.
//  Way2 valid tag=20'h12345 cnt=7 at idx 5, req 24'h123455 -> wren cyc3 line=2 cnt=8, rsp hit=1 way=2 cnt=8.
//  Ways 1 and 3 both match -> way=1 reported and written; cnt=15'h7FFF -> written/returned 15'h7FFF.
//  rsp_ready held 0 for 5 cycles -> rsp fields stable, req_ready=0, no rden; release -> IDLE, next req accepted.
//  hit_count at 16'hFFFF plus one hit -> stays FFFF; stat_clr same cycle as miss -> miss_count=0.
//  rst_n low during UPD -> next cycle IDLE, req_ready=1, rsp_valid=0, wren=0, counters 0.

Source files
------------

// File: rtl/drc_lookup.sv
// drc_lookup: lookup/update controller sitting on the DRC side of the tag/data SRAM.
// A 24-bit request address is split into a set index (low bits) and a tag
// (high bits). The indexed set is read, all ways are tag-compared, and the
// result (hit/miss plus line contents) is returned. On a hit the line is
// written back with its 15-bit use count incremented (saturating).
// Hit/miss statistics are kept in saturating 16-bit counters.
//
// Handshakes (valid/ready): a transfer happens on a rising edge where valid
// and ready are both 1. A producer holds valid and its payload stable until
// that edge. req_ready is a pure decode of IDLE. rsp_valid stays high, with
// fields stable, until rsp_ready is seen.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    lookup request channel
//   rsp_valid/rsp_ready             response channel
//   rsp_hit/way/type/syn/cnt/data   response payload (all zero on a miss)
//   raddr/rden                      SRAM read port; rdata_* valid the cycle after rden
//   rdata_valid/type/syn/tag/cnt/data  per-way read data
//   waddr/wren/wdata_line           SRAM write port (index, enable, way)
//   wdata_type/syn/tag/cnt/data     SRAM write data
//   stat_clr                        synchronous clear of both statistics counters
//   hit_count/miss_count            saturating statistics counters
//   dbg_state                       current FSM state (debug visibility)
module drc_lookup #(
  parameter int N_ENTRY = 64,
  parameter int N_WAY = 4,
  localparam int IDX_SIZE = $clog2(N_ENTRY / N_WAY),
  localparam int WAY_WIDTH = $clog2(N_WAY),
  localparam int TAG_SIZE = 24 - IDX_SIZE
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [23:0]                       req_addr,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic                              rsp_hit,
  output logic [WAY_WIDTH-1:0]              rsp_way,
  output logic [1:0]                        rsp_type,
  output logic [31:0]                       rsp_syn,
  output logic [14:0]                       rsp_cnt,
  output logic [271:0]                      rsp_data,
  output logic [IDX_SIZE-1:0]               raddr,
  output logic                              rden,
  input  logic [N_WAY-1:0]                  rdata_valid,
  input  logic [N_WAY-1:0][1:0]             rdata_type,
  input  logic [N_WAY-1:0][31:0]            rdata_syn,
  input  logic [N_WAY-1:0][TAG_SIZE-1:0]    rdata_tag,
  input  logic [N_WAY-1:0][14:0]            rdata_cnt,
  input  logic [N_WAY-1:0][271:0]           rdata_data,
  output logic [IDX_SIZE-1:0]               waddr,
  output logic                              wren,
  output logic [WAY_WIDTH-1:0]              wdata_line,
  output logic [1:0]                        wdata_type,
  output logic [31:0]                       wdata_syn,
  output logic [TAG_SIZE-1:0]               wdata_tag,
  output logic [14:0]                       wdata_cnt,
  output logic [271:0]                      wdata_data,
  input  logic                              stat_clr,
  output logic [15:0]                       hit_count,
  output logic [15:0]                       miss_count,
  output logic [2:0]                        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_CMP  = 3'd2,
    S_UPD  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t state, next;

  logic [IDX_SIZE-1:0]  idx_q;
  logic [TAG_SIZE-1:0]  tag_q;
  logic                 hit_q;
  logic [WAY_WIDTH-1:0] way_q;
  logic [1:0]           type_q;
  logic [31:0]          syn_q;
  logic [14:0]          cnt_q;
  logic [271:0]         data_q;

  logic                 hit_any;
  logic [WAY_WIDTH-1:0] hit_way;
  logic [14:0]          cnt_inc;

  // Tag compare across ways. Scanning from the top way down means the
  // lowest matching way is the last assignment and therefore wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = N_WAY - 1; w >= 0; w--) begin
      if (rdata_valid[w] && (rdata_tag[w] == tag_q)) begin
        hit_any = 1'b1;
        hit_way = WAY_WIDTH'(w);
      end
    end
  end

  assign cnt_inc = (rdata_cnt[hit_way] == 15'h7FFF) ? 15'h7FFF : rdata_cnt[hit_way] + 15'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next;
  end

  always_comb begin
    next      = state;
    req_ready = 1'b0;
    rden      = 1'b0;
    wren      = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) next = S_RD;
      end
      S_RD: begin
        rden = 1'b1;
        next = S_CMP;
      end
      S_CMP:  next = hit_any ? S_UPD : S_RESP;
      S_UPD: begin
        wren = 1'b1;
        next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

  // Request capture and result registers. The result registers feed both the
  // response payload and the write-back data, so a miss clears them to give
  // the all-zero miss response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      tag_q  <= '0;
      hit_q  <= 1'b0;
      way_q  <= '0;
      type_q <= '0;
      syn_q  <= '0;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        idx_q <= req_addr[IDX_SIZE-1:0];
        tag_q <= req_addr[23:IDX_SIZE];
      end
      if (state == S_CMP) begin
        if (hit_any) begin
          hit_q  <= 1'b1;
          way_q  <= hit_way;
          type_q <= rdata_type[hit_way];
          syn_q  <= rdata_syn[hit_way];
          cnt_q  <= cnt_inc;
          data_q <= rdata_data[hit_way];
        end else begin
          hit_q  <= 1'b0;
          way_q  <= '0;
          type_q <= '0;
          syn_q  <= '0;
          cnt_q  <= '0;
          data_q <= '0;
        end
      end
    end
  end

  // Statistics: a clear in the same cycle as a compare beats the increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (stat_clr) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == S_CMP) begin
      if (hit_any) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end

  // Both SRAM addresses come from the captured index, so they hold their
  // last value between lookups.
  assign raddr      = idx_q;
  assign waddr      = idx_q;
  assign wdata_line = way_q;
  assign wdata_tag  = tag_q;
  assign wdata_type = type_q;
  assign wdata_syn  = syn_q;
  assign wdata_cnt  = cnt_q;
  assign wdata_data = data_q;

  assign rsp_hit  = hit_q;
  assign rsp_way  = way_q;
  assign rsp_type = type_q;
  assign rsp_syn  = syn_q;
  assign rsp_cnt  = cnt_q;
  assign rsp_data = data_q;

  assign dbg_state = state;

endmodule

// File: tb/tb_drc_lookup.sv
// tb_drc_lookup: self-checking bench for drc_lookup. A behavioural SRAM
// answers the DUT's read/write ports; a separate reference copy of the
// contents, maintained only by the bench, produces expected responses that
// are queued at request time and compared when the response handshakes.
module tb_drc_lookup;

  localparam int RW = 324;  // {hit, way, type, syn, cnt, data}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [23:0]  req_addr = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic         rsp_hit;
  logic [1:0]   rsp_way;
  logic [1:0]   rsp_type;
  logic [31:0]  rsp_syn;
  logic [14:0]  rsp_cnt;
  logic [271:0] rsp_data;
  logic [3:0]   raddr;
  logic         rden;
  logic [3:0]          rdata_valid;
  logic [3:0][1:0]     rdata_type;
  logic [3:0][31:0]    rdata_syn;
  logic [3:0][19:0]    rdata_tag;
  logic [3:0][14:0]    rdata_cnt;
  logic [3:0][271:0]   rdata_data;
  logic [3:0]   waddr;
  logic         wren;
  logic [1:0]   wdata_line;
  logic [1:0]   wdata_type;
  logic [31:0]  wdata_syn;
  logic [19:0]  wdata_tag;
  logic [14:0]  wdata_cnt;
  logic [271:0] wdata_data;
  logic         stat_clr = 1'b0;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
  logic [2:0]   dbg_state;

  drc_lookup dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_way(rsp_way), .rsp_type(rsp_type), .rsp_syn(rsp_syn),
    .rsp_cnt(rsp_cnt), .rsp_data(rsp_data),
    .raddr(raddr), .rden(rden),
    .rdata_valid(rdata_valid), .rdata_type(rdata_type), .rdata_syn(rdata_syn),
    .rdata_tag(rdata_tag), .rdata_cnt(rdata_cnt), .rdata_data(rdata_data),
    .waddr(waddr), .wren(wren), .wdata_line(wdata_line),
    .wdata_type(wdata_type), .wdata_syn(wdata_syn), .wdata_tag(wdata_tag),
    .wdata_cnt(wdata_cnt), .wdata_data(wdata_data),
    .stat_clr(stat_clr), .hit_count(hit_count), .miss_count(miss_count),
    .dbg_state(dbg_state)
  );

  // ---------------- SRAM model (written by backdoor or by the DUT) ----------
  logic         mem_v    [16][4];
  logic [19:0]  mem_tag  [16][4];
  logic [14:0]  mem_cnt  [16][4];
  logic [1:0]   mem_type [16][4];
  logic [31:0]  mem_syn  [16][4];
  logic [271:0] mem_data [16][4];

  logic         bd_we = 1'b0;
  logic [3:0]   bd_idx = '0;
  logic [1:0]   bd_way = '0;
  logic         bd_v = 1'b0;
  logic [19:0]  bd_tag = '0;
  logic [14:0]  bd_cnt = '0;
  logic [1:0]   bd_type = '0;
  logic [31:0]  bd_syn = '0;
  logic [271:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) begin
      mem_v[bd_idx][bd_way]    <= bd_v;
      mem_tag[bd_idx][bd_way]  <= bd_tag;
      mem_cnt[bd_idx][bd_way]  <= bd_cnt;
      mem_type[bd_idx][bd_way] <= bd_type;
      mem_syn[bd_idx][bd_way]  <= bd_syn;
      mem_data[bd_idx][bd_way] <= bd_data;
    end else if (wren) begin
      mem_v[waddr][wdata_line]    <= 1'b1;
      mem_tag[waddr][wdata_line]  <= wdata_tag;
      mem_cnt[waddr][wdata_line]  <= wdata_cnt;
      mem_type[waddr][wdata_line] <= wdata_type;
      mem_syn[waddr][wdata_line]  <= wdata_syn;
      mem_data[waddr][wdata_line] <= wdata_data;
    end
    if (rden) begin
      for (int w = 0; w < 4; w++) begin
        rdata_valid[w] <= mem_v[raddr][w];
        rdata_tag[w]   <= mem_tag[raddr][w];
        rdata_cnt[w]   <= mem_cnt[raddr][w];
        rdata_type[w]  <= mem_type[raddr][w];
        rdata_syn[w]   <= mem_syn[raddr][w];
        rdata_data[w]  <= mem_data[raddr][w];
      end
    end
  end

  // ---------------- reference contents and scoreboard -----------------------
  logic         ref_v    [16][4];
  logic [19:0]  ref_tag  [16][4];
  logic [14:0]  ref_cnt  [16][4];
  logic [1:0]   ref_type [16][4];
  logic [31:0]  ref_syn  [16][4];
  logic [271:0] ref_data [16][4];

  logic [RW-1:0] exp_q[$];
  logic [15:0]   hit_exp = '0;
  logic [15:0]   miss_exp = '0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp_v);
    end
  endtask

  function automatic logic [271:0] rand_data();
    logic [287:0] t;
    t = '0;
    for (int k = 0; k < 9; k++) t = {t[255:0], $urandom()};
    return t[271:0];
  endfunction

  task automatic bd_write(input logic [3:0] i, input logic [1:0] w, input logic v,
                          input logic [19:0] t, input logic [14:0] c, input logic [1:0] ty,
                          input logic [31:0] s, input logic [271:0] d);
    ref_v[i][w] = v; ref_tag[i][w] = t; ref_cnt[i][w] = c;
    ref_type[i][w] = ty; ref_syn[i][w] = s; ref_data[i][w] = d;
    bd_idx = i; bd_way = w; bd_v = v; bd_tag = t; bd_cnt = c;
    bd_type = ty; bd_syn = s; bd_data = d;
    bd_we = 1'b1;
    @(posedge clk);
    #1 bd_we = 1'b0;
  endtask

  // One lookup: build the expected response from the reference, drive the
  // request, watch the SRAM ports cycle by cycle, and compare on handshake.
  // hold: cycles rsp_ready stays low while rsp_valid is up.
  // clr_cmp: pulse stat_clr across the compare edge.
  // rst_at: assert reset at that cycle after acceptance (0 = never).
  task automatic lookup(input logic [23:0] addr, input int hold, input bit clr_cmp, input int rst_at);
    logic [3:0]    i;
    logic [19:0]   t;
    logic [RW-1:0] exp_v, got, first;
    logic          hit;
    logic [1:0]    fw;
    logic [14:0]   c;
    int cyc, rd_cyc, wr_cyc, rsp_cyc, rd_n, wr_n, seen;
    bit done, aborted;
    i = addr[3:0];
    t = addr[23:4];
    hit = 1'b0; fw = '0; c = '0;
    for (int w = 0; w < 4; w++) begin
      if (!hit && ref_v[i][w] && ref_tag[i][w] == t) begin
        hit = 1'b1;
        fw = 2'(w);
      end
    end
    if (hit) begin
      c = (ref_cnt[i][fw] == 15'h7FFF) ? 15'h7FFF : ref_cnt[i][fw] + 15'd1;
      ref_cnt[i][fw] = c;
      exp_v = {1'b1, fw, ref_type[i][fw], ref_syn[i][fw], c, ref_data[i][fw]};
    end else begin
      exp_v = '0;
    end
    if (clr_cmp) begin
      hit_exp = '0; miss_exp = '0;
    end else if (hit) begin
      if (hit_exp != 16'hFFFF) hit_exp = hit_exp + 16'd1;
    end else begin
      if (miss_exp != 16'hFFFF) miss_exp = miss_exp + 16'd1;
    end
    exp_q.push_back(exp_v);

    rsp_ready = (hold == 0);
    @(negedge clk);
    check("req_ready_idle", RW'(req_ready), RW'(1'b1));
    req_valid = 1'b1;
    req_addr = addr;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1; rd_cyc = -1; wr_cyc = -1; rsp_cyc = -1;
    rd_n = 0; wr_n = 0; seen = 0; done = 0; aborted = 0;
    first = '0;
    while (!done && cyc < 40) begin
      got = {rsp_hit, rsp_way, rsp_type, rsp_syn, rsp_cnt, rsp_data};
      check("rd_wr_excl", RW'(rden & wren), RW'(1'b0));
      if (rden) begin
        rd_n++; rd_cyc = cyc;
        check("raddr", RW'(raddr), RW'(i));
      end
      if (wren) begin
        wr_n++; wr_cyc = cyc;
        check("waddr", RW'(waddr), RW'(i));
        check("wdata_line", RW'(wdata_line), RW'(fw));
        check("wdata_cnt", RW'(wdata_cnt), RW'(c));
        check("wdata_tag", RW'(wdata_tag), RW'(t));
        check("wdata_data", RW'(wdata_data), RW'(ref_data[i][fw]));
      end
      stat_clr = clr_cmp && (cyc == 2);
      if (rst_at == cyc) begin
        check("upd_wren", RW'(wren), RW'(1'b1));
        rst_n = 1'b0;
        #1;
        check("rst_state", RW'(dbg_state), RW'(3'd0));
        check("rst_req_ready", RW'(req_ready), RW'(1'b1));
        check("rst_rsp_valid", RW'(rsp_valid), RW'(1'b0));
        check("rst_wren", RW'(wren), RW'(1'b0));
        check("rst_hit_count", RW'(hit_count), RW'(16'h0));
        check("rst_miss_count", RW'(miss_count), RW'(16'h0));
        void'(exp_q.pop_front());
        hit_exp = '0; miss_exp = '0;
        aborted = 1; done = 1;
      end else if (rsp_valid) begin
        if (rsp_cyc < 0) begin
          rsp_cyc = cyc;
          first = got;
        end else begin
          check("rsp_stable", got, first);
        end
        seen++;
        if (!rsp_ready) begin
          check("busy_req_ready", RW'(req_ready), RW'(1'b0));
          check("busy_state", RW'(dbg_state), RW'(3'd4));
        end
        if (seen > hold) begin
          check("sb_size", RW'(exp_q.size()), RW'(1));
          if (exp_q.size() > 0) check("rsp", got, exp_q.pop_front());
          rsp_ready = 1'b1;
          done = 1;
        end
      end
      if (!done) begin
        @(negedge clk);
        cyc++;
      end
    end
    check("timeout", RW'(done), RW'(1'b1));
    stat_clr = 1'b0;
    if (aborted) begin
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
    end else begin
      @(negedge clk);
      check("post_rsp_valid", RW'(rsp_valid), RW'(1'b0));
      check("post_req_ready", RW'(req_ready), RW'(1'b1));
      check("rden_cycle", RW'(rd_cyc), RW'(1));
      check("rden_pulses", RW'(rd_n), RW'(1));
      check("wren_pulses", RW'(wr_n), RW'(hit ? 1 : 0));
      if (hit) check("wren_cycle", RW'(wr_cyc), RW'(3));
      check("rsp_cycle", RW'(rsp_cyc), RW'(hit ? 4 : 3));
      check("hit_count", RW'(hit_count), RW'(hit_exp));
      check("miss_count", RW'(miss_count), RW'(miss_exp));
      if (hit) begin
        check("mem_cnt", RW'(mem_cnt[i][fw]), RW'(ref_cnt[i][fw]));
        check("mem_tag", RW'(mem_tag[i][fw]), RW'(ref_tag[i][fw]));
        check("mem_data", RW'(mem_data[i][fw]), RW'(ref_data[i][fw]));
      end
    end
  endtask

  // ---------------- test sequence --------------------------------------------
  initial begin
    // Clear the SRAM while the DUT sits in reset.
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < 4; w++)
        bd_write(4'(i), 2'(w), 1'b0, '0, '0, '0, '0, '0);
    @(negedge clk);
    check("reset_state", RW'(dbg_state), RW'(3'd0));
    check("reset_req_ready", RW'(req_ready), RW'(1'b1));
    check("reset_rsp_valid", RW'(rsp_valid), RW'(1'b0));
    check("reset_rden", RW'(rden), RW'(1'b0));
    check("reset_wren", RW'(wren), RW'(1'b0));
    check("reset_raddr", RW'(raddr), RW'(4'h0));
    check("reset_wdata_cnt", RW'(wdata_cnt), RW'(15'h0));
    check("reset_rsp", RW'({rsp_hit, rsp_way, rsp_type, rsp_syn, rsp_cnt, rsp_data}), RW'(0));
    check("reset_hit_count", RW'(hit_count), RW'(16'h0));
    check("reset_miss_count", RW'(miss_count), RW'(16'h0));
    rst_n = 1'b1;
    @(negedge clk);

    // Empty SRAM: miss.
    lookup(24'h123455, 0, 1'b0, 0);
    // Way 2 at index 5 hits; a second lookup sees the written-back count.
    bd_write(4'd5, 2'd2, 1'b1, 20'h12345, 15'd7, 2'd2, 32'hDEADBEEF, rand_data());
    lookup(24'h123455, 0, 1'b0, 0);
    lookup(24'h123455, 0, 1'b0, 0);
    // Ways 1 and 3 both match: lowest way wins; count already saturated.
    bd_write(4'd9, 2'd1, 1'b1, 20'h0ABCD, 15'h7FFF, 2'd1, 32'h11112222, rand_data());
    bd_write(4'd9, 2'd3, 1'b1, 20'h0ABCD, 15'd3, 2'd3, 32'h33334444, rand_data());
    lookup(24'h0ABCD9, 0, 1'b0, 0);
    check("way3_untouched", RW'(mem_cnt[9][3]), RW'(15'd3));
    // Response back-pressure for five cycles.
    lookup(24'h123455, 5, 1'b0, 0);

    // Random contents from a small tag pool, random lookups.
    for (int i = 0; i < 16; i++)
      for (int w = 0; w < 4; w++)
        bd_write(4'(i), 2'(w), 1'($urandom_range(0, 1)), 20'h0AB00 + 20'($urandom_range(0, 3)),
                 ($urandom_range(0, 7) == 0) ? 15'h7FFF : 15'($urandom_range(0, 200)),
                 2'($urandom_range(0, 3)), $urandom(), rand_data());
    for (int n = 0; n < 30; n++)
      lookup({20'h0AB00 + 20'($urandom_range(0, 4)), 4'($urandom_range(0, 15))},
             $urandom_range(0, 2), 1'b0, 0);

    // Hit counter saturation.
    bd_write(4'd0, 2'd0, 1'b1, 20'h00777, 15'd100, 2'd1, 32'hCAFEF00D, rand_data());
    @(negedge clk);
    force dut.hit_count = 16'hFFFE;
    @(negedge clk);
    release dut.hit_count;
    hit_exp = 16'hFFFE;
    lookup(24'h007770, 0, 1'b0, 0);
    lookup(24'h007770, 0, 1'b0, 0);

    // stat_clr in the same cycle as a miss.
    lookup(24'hFFFFF3, 0, 1'b1, 0);

    // Reset while the write-back is in progress, then resynchronise the line.
    lookup(24'h007770, 0, 1'b0, 3);
    bd_write(4'd0, 2'd0, 1'b1, 20'h00777, ref_cnt[0][0], ref_type[0][0], ref_syn[0][0], ref_data[0][0]);
    lookup(24'h007770, 1, 1'b0, 0);
    lookup(24'h123455, 0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
